// File: rtl/ras_cmd_issuer_if.sv
// ras_cmd_issuer_if: event channel from decode/resolve into the RAS command issuer.
interface ras_cmd_issuer_if #(
    parameter int WIDTH = 32
);
    logic             ev_valid;
    logic             ev_ready;
    logic [2:0]       ev_type;
    logic [WIDTH-1:0] ev_addr;
    logic             flush;
    modport master (output ev_valid, ev_type, ev_addr, flush, input ev_ready);
    modport slave  (input ev_valid, ev_type, ev_addr, flush, output ev_ready);
endinterface

// File: rtl/ras_cmd_issuer.sv
// ras_cmd_issuer: queues call/return/branch events and serialises them into RAS stack commands.
// Optional RAS_CMD_STATS_EN adds saturating stat_* counters.
module ras_cmd_issuer #(
    parameter int WIDTH         = 32,
    parameter int MAXBRANCHES   = 16,
    parameter int BRANCHES_ADDR = 4,
    parameter int EV_DEPTH      = 4,
    parameter int EV_ADDR       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ras_cmd_issuer_if.slave        ev,
    output logic                   ras_push,
    output logic                   ras_pop,
    output logic                   ras_branch,
    output logic                   ras_close_valid,
    output logic                   ras_close_invalid,
    output logic [WIDTH-1:0]       ras_din,
    input  logic [WIDTH-1:0]       ras_dout,
    input  logic                   ras_pop_valid,
    output logic                   pred_valid,
    output logic [WIDTH-1:0]       pred_addr,
    output logic                   pred_hit,
    output logic [BRANCHES_ADDR:0] open_cnt,
    output logic                   err_orphan
`ifdef RAS_CMD_STATS_EN
    ,
    output logic [15:0]            stat_calls,
    output logic [15:0]            stat_rets,
    output logic [15:0]            stat_underflow,
    output logic [15:0]            stat_mispredict
`endif
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RECOVER = 2'd2;
    localparam logic [2:0] CALL = 3'd0, RET = 3'd1, TAILCALL = 3'd2, BR_OPEN = 3'd3, BR_OK = 3'd4, BR_BAD = 3'd5;
    logic [WIDTH+2:0]     mem [EV_DEPTH];
    logic [EV_ADDR-1:0]   wptr, rptr;
    logic [EV_ADDR:0]     cnt, cnt_nxt;
    logic [1:0]           state;
    logic [2:0]           hd_type;
    logic [WIDTH-1:0]     hd_addr;
    logic                 wr, rd, act, has_open, br_full, is_close;
    assign {hd_type, hd_addr} = mem[rptr];
    assign ev.ev_ready = cnt != (EV_ADDR+1)'(EV_DEPTH);
    assign wr       = ev.ev_valid && ev.ev_ready && !ev.flush;
    // ISSUE implies a non-empty queue; a flush suppresses issue of the head
    assign act      = state == ISSUE && !ev.flush;
    assign has_open = open_cnt != '0;
    assign br_full  = open_cnt == (BRANCHES_ADDR+1)'(MAXBRANCHES);
    assign is_close = hd_type == BR_OK || hd_type == BR_BAD;
    assign rd       = act && !(hd_type == BR_OPEN && br_full);
    assign ras_push          = act && (hd_type == CALL || hd_type == TAILCALL);
    assign ras_pop           = act && (hd_type == RET || hd_type == TAILCALL);
    assign ras_branch        = act && hd_type == BR_OPEN && !br_full;
    assign ras_close_valid   = act && hd_type == BR_OK && has_open;
    assign ras_close_invalid = act && hd_type == BR_BAD && has_open;
    assign ras_din           = ras_push ? hd_addr : '0;
    assign pred_addr         = pred_valid ? ras_dout : '0;
    assign cnt_nxt = ev.flush ? '0 : cnt + (EV_ADDR+1)'(wr) - (EV_ADDR+1)'(rd);
    always_ff @(posedge clk)
        if (wr) mem[wptr] <= {ev.ev_type, ev.ev_addr};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            open_cnt   <= '0;
            err_orphan <= 1'b0;
            pred_valid <= 1'b0;
            pred_hit   <= 1'b0;
        end else begin
            state      <= ras_close_invalid ? RECOVER : (cnt_nxt != '0 ? ISSUE : IDLE);
            cnt        <= cnt_nxt;
            wptr       <= ev.flush ? '0 : wptr + EV_ADDR'(wr);
            rptr       <= ev.flush ? '0 : rptr + EV_ADDR'(rd);
            open_cnt   <= ras_close_invalid ? '0 :
                          open_cnt + (BRANCHES_ADDR+1)'(ras_branch) - (BRANCHES_ADDR+1)'(ras_close_valid);
            err_orphan <= err_orphan || (act && is_close && !has_open);
            pred_valid <= ras_pop;
            pred_hit   <= ras_pop && ras_pop_valid;
        end
    end
`ifdef RAS_CMD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_calls      <= '0;
            stat_rets       <= '0;
            stat_underflow  <= '0;
            stat_mispredict <= '0;
        end else begin
            if (ras_push && stat_calls != 16'hFFFF) stat_calls <= stat_calls + 16'd1;
            if (ras_pop && stat_rets != 16'hFFFF) stat_rets <= stat_rets + 16'd1;
            if (ras_pop && !ras_pop_valid && stat_underflow != 16'hFFFF) stat_underflow <= stat_underflow + 16'd1;
            if (ras_close_invalid && stat_mispredict != 16'hFFFF) stat_mispredict <= stat_mispredict + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ras_cmd_issuer.sv
// tb_ras_cmd_issuer: directed scoreboard bench for ras_cmd_issuer with a behavioural stack.
module tb_ras_cmd_issuer;
    typedef struct {logic [4:0] s; logic [31:0] d;} cmd_t;
    typedef struct {logic h; logic [31:0] a;} pr_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
    logic [31:0] ras_din, ras_dout = 32'h0, pred_addr;
    logic        ras_pop_valid, pred_valid, pred_hit, err_orphan;
    logic [4:0]  open_cnt;
    int          tests = 0, fails = 0;
    cmd_t        cq[$];
    pr_t         pq[$];
    logic [31:0] rstk[$];
    int          ropen = 0;
    logic [31:0] stk [64];
    int          sp = 0;
    logic        prev_pop = 1'b0, prev_ci = 1'b0;

    ras_cmd_issuer_if #(.WIDTH(32)) evi ();

    ras_cmd_issuer dut (
        .clk(clk), .rst_n(rst_n), .ev(evi),
        .ras_push(ras_push), .ras_pop(ras_pop), .ras_branch(ras_branch),
        .ras_close_valid(ras_close_valid), .ras_close_invalid(ras_close_invalid),
        .ras_din(ras_din), .ras_dout(ras_dout), .ras_pop_valid(ras_pop_valid),
        .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_hit(pred_hit),
        .open_cnt(open_cnt), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    // behavioural stack: registered read data, no speculation restore
    assign ras_pop_valid = sp != 0;
    always @(posedge clk) begin
        if (ras_pop) ras_dout <= (sp != 0) ? stk[sp-1] : 32'hDEAD_BEEF;
        if (ras_push && ras_pop) begin
            if (sp != 0) stk[sp-1] <= ras_din;
            else begin stk[0] <= ras_din; sp <= 1; end
        end else if (ras_push) begin
            stk[sp] <= ras_din; sp <= sp + 1;
        end else if (ras_pop && sp != 0) sp <= sp - 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        cmd_t c;
        pr_t p;
        logic [4:0] s;
        if (!rst_n) begin
            prev_pop <= 1'b0;
            prev_ci  <= 1'b0;
        end else begin
            s = {ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid};
            chk("open_cnt_max", 64'(open_cnt <= 5'd16), 1);
            chk("pred_latency", pred_valid, prev_pop);
            if (prev_ci) chk("recover_idle", s, 0);
            if (s != 0) begin
                if (cq.size() == 0) chk("unexpected_cmd", s, 0);
                else begin
                    c = cq.pop_front();
                    chk("cmd", s, c.s);
                    chk("din", ras_din, c.d);
                end
            end
            if (pred_valid) begin
                if (pq.size() == 0) chk("unexpected_pred", pred_valid, 0);
                else begin
                    p = pq.pop_front();
                    chk("pred_hit", pred_hit, p.h);
                    if (p.h) chk("pred_addr", pred_addr, p.a);
                end
            end
            prev_pop <= ras_pop;
            prev_ci  <= ras_close_invalid;
        end
    end

    task automatic model(input logic [2:0] t, input logic [31:0] a);
        pr_t p;
        if (t == 3'd1 || t == 3'd2) begin
            p.h = rstk.size() != 0;
            p.a = p.h ? rstk[$] : 32'h0;
            pq.push_back(p);
            if (p.h) void'(rstk.pop_back());
        end
        case (t)
            3'd0: begin cq.push_back('{5'b10000, a}); rstk.push_back(a); end
            3'd1: cq.push_back('{5'b01000, 32'h0});
            3'd2: begin cq.push_back('{5'b11000, a}); rstk.push_back(a); end
            3'd3: begin cq.push_back('{5'b00100, 32'h0}); ropen++; end
            3'd4: if (ropen > 0) begin cq.push_back('{5'b00010, 32'h0}); ropen--; end
            3'd5: if (ropen > 0) begin cq.push_back('{5'b00001, 32'h0}); ropen = 0; end
            default: ;
        endcase
    endtask

    task automatic send(input logic [2:0] t, input logic [31:0] a, input bit e);
        int n = 0;
        while (!evi.ev_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("send_ready", evi.ev_ready, 1);
        if (e) model(t, a);
        evi.ev_valid = 1'b1;
        evi.ev_type  = t;
        evi.ev_addr  = a;
        @(posedge clk); #1;
        evi.ev_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((cq.size() != 0 || pq.size() != 0) && n < 200) begin @(posedge clk); #1; n++; end
        repeat (4) @(posedge clk);
        #1;
        chk("drain", 64'(cq.size() + pq.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        evi.ev_valid = 1'b0; evi.ev_type = 3'd0; evi.ev_addr = 32'h0; evi.flush = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", evi.ev_ready, 1);
        chk("rst_strobes", {ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid}, 0);
        chk("rst_din", ras_din, 0);
        chk("rst_pred", {pred_valid, pred_hit}, 0);
        chk("rst_pred_addr", pred_addr, 0);
        chk("rst_open", open_cnt, 0);
        chk("rst_orphan", err_orphan, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        // nested calls and returns
        send(3'd0, 32'h1000, 1); send(3'd0, 32'h2000, 1); send(3'd1, 0, 1); send(3'd1, 0, 1);
        drain();
        // return on an empty stack
        send(3'd1, 0, 1);
        drain();
        // mispredict with recovery cycle
        send(3'd3, 0, 1); send(3'd0, 32'h3000, 1); send(3'd5, 0, 1); send(3'd1, 0, 1);
        drain();
        chk("open_after_bad", open_cnt, 0);
        // fill and drain the branch list, then an orphan close
        for (int i = 0; i < 16; i++) send(3'd3, 0, 1);
        drain();
        chk("open_full", open_cnt, 16);
        for (int i = 0; i < 16; i++) send(3'd4, 0, 1);
        drain();
        chk("open_empty", open_cnt, 0);
        chk("no_orphan", err_orphan, 0);
        send(3'd4, 0, 1);
        drain();
        chk("orphan_set", err_orphan, 1);
        // stall on a full branch list, fill the queue, flush it
        for (int i = 0; i < 16; i++) send(3'd3, 0, 1);
        drain();
        send(3'd3, 0, 0); send(3'd0, 32'h7000, 0); send(3'd1, 0, 0); send(3'd0, 32'h7100, 0);
        chk("queue_full", evi.ev_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_open", open_cnt, 16);
        evi.flush = 1'b1;
        @(posedge clk); #1;
        evi.flush = 1'b0;
        chk("flush_ready", evi.ev_ready, 1);
        evi.flush = 1'b1; evi.ev_valid = 1'b1; evi.ev_type = 3'd0; evi.ev_addr = 32'h5555;
        @(posedge clk); #1;
        evi.flush = 1'b0; evi.ev_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_enq_dropped", evi.ev_ready, 1);
        chk("flush_keeps_open", open_cnt, 16);
        for (int i = 0; i < 16; i++) send(3'd4, 0, 1);
        drain();
        chk("open_after_flush", open_cnt, 0);
        // tail call replaces the top
        send(3'd0, 32'h1000, 1); send(3'd2, 32'h4000, 1); send(3'd1, 0, 1);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
